// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC / instruction-fetch controller.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ERR   = 2'd3
  } state_e;

  localparam logic [31:0] INSTR_BYTES      = 32'd4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Fetch wait counter; flags the cycle a FETCH reaches its ack-less limit.
// Only built when FETCH_TIMEOUT_EN is defined.
`ifdef FETCH_TIMEOUT_EN
module fetch_timeout_ctr #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic hit_o
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = 8'd0;
    else if (inc_i) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

  assign hit_o = inc_i && !clr_i && (cnt_q == LAST);

endmodule
`endif

// File: rtl/pc_fetch_ctrl.sv
// PC holder and req/ack instruction fetcher with one-deep decode buffer.
// Optional ack timeout to ERR when FETCH_TIMEOUT_EN is defined.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR   = DEF_RESET_VECTOR,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_s,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        live, redir_ok, redir_bad, tmo;

  assign live      = (state_q == FETCH) || (state_q == HOLD);
  assign redir_ok  = live && redirect && (redirect_pc[1:0] == 2'b00);
  assign redir_bad = live && redirect && (redirect_pc[1:0] != 2'b00);

`ifdef FETCH_TIMEOUT_EN
  fetch_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i ((state_q != FETCH) || redirect),
    .inc_i ((state_q == FETCH) && !imem_ack),
    .hit_o (tmo)
  );
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = |TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Redirect outranks ack, ready and timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (redir_bad)     state_d = ERR;
        else if (redir_ok) state_d = FETCH;
        else if (imem_ack) state_d = HOLD;
        else if (tmo)      state_d = ERR;
      end
      HOLD: begin
        if (redir_bad)        state_d = ERR;
        else if (redir_ok)    state_d = FETCH;
        else if (instr_ready) state_d = FETCH;
      end
      ERR:   state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fetch_err   = 1'b0;
    unique case (state_q)
      FETCH:   imem_req    = 1'b1;
      HOLD:    instr_valid = 1'b1;
      ERR:     fetch_err   = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    if (redir_ok) begin
      pc_d = redirect_pc;
    end else if (state_q == FETCH && imem_ack && !redir_bad) begin
      pc_d    = add_s;
      instr_d = imem_rdata;
      ipc_d   = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_VECTOR;
      instr_q <= 32'd0;
      ipc_q   <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  assign add_a     = pc_q;
  assign add_b     = INSTR_BYTES;
  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign instr_pc  = ipc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomized bench for pc_fetch_ctrl with a transaction-level fetch model.
// Timeout expectations follow FETCH_TIMEOUT_EN.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam int          TMO = 15;
  localparam int          NRUN = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] add_a, add_b, add_s;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_err;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign add_s      = add_a + add_b;
  assign imem_rdata = mem(imem_addr);

  pc_fetch_ctrl #(
    .RESET_VECTOR   (RV),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .add_a       (add_a),
    .add_b       (add_b),
    .add_s       (add_s),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_err   (fetch_err)
  );

  // Reference model: state after the next clock edge
  logic [31:0] m_pc;
  bit          m_started, m_err;
  int          m_nack;
  logic [31:0] exp_ins[$];
  logic [31:0] exp_pc[$];

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  active = 1'b0;
  bit  fetching;

  int ack_t[NRUN] = '{100, 60, 30, 90, 0, 80, 50, 90, 70, 100};
  int rdy_t[NRUN] = '{100, 50, 70, 80, 100, 30, 60, 90, 40, 100};
  int rd_t[NRUN]  = '{0,   5,  8,  4,  0,   10, 6,  3,  12, 2};
  int mis_t[NRUN] = '{0,   0,  0,  0,  0,   0,  20, 0,  5,  0};
  int cyc_t[NRUN] = '{200, 250, 250, 250, 120, 250, 200, 250, 250, 250};
  int ack_pct, rdy_pct, rd_pct, mis_pct;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc      = RV;
    m_started = 1'b0;
    m_err     = 1'b0;
    m_nack    = 0;
    exp_ins.delete();
    exp_pc.delete();
  endtask

  task automatic reset_checks();
    check("rst imem_req", {31'd0, imem_req}, 32'd0);
    check("rst instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst instr", instr, 32'd0);
    check("rst instr_pc", instr_pc, 32'd0);
    check("rst fetch_err", {31'd0, fetch_err}, 32'd0);
    check("rst add_a", add_a, RV);
    check("rst add_b", add_b, 32'd4);
  endtask

  task automatic drive();
    logic [31:0] tgt;
    imem_ack    = ($urandom_range(99) < ack_pct);
    instr_ready = ($urandom_range(99) < rdy_pct);
    redirect    = ($urandom_range(99) < rd_pct);
    case ($urandom_range(4))
      0:       tgt = 32'h0000_0100;
      1:       tgt = 32'hFFFF_FFFC;
      2:       tgt = 32'hFFFF_FFF0;
      default: tgt = $urandom & 32'hFFFF_FFFC;
    endcase
    if ($urandom_range(99) < mis_pct) tgt[1:0] = 2'($urandom_range(3, 1));
    redirect_pc = tgt;

    if (!m_started) begin
      m_started = 1'b1;
    end else if (!m_err) begin
      if (redirect) begin
        exp_ins.delete();
        exp_pc.delete();
        m_nack = 0;
        if (tgt[1:0] != 2'b00) m_err = 1'b1;
        else                   m_pc  = tgt;
      end else if (exp_pc.size() == 0) begin
        if (imem_ack) begin
          exp_ins.push_back(mem(m_pc));
          exp_pc.push_back(m_pc);
          m_pc   = m_pc + 32'd4;
          m_nack = 0;
        end else begin
          m_nack++;
`ifdef FETCH_TIMEOUT_EN
          if (m_nack == TMO) m_err = 1'b1;
`endif
        end
      end else if (instr_ready) begin
        void'(exp_ins.pop_front());
        void'(exp_pc.pop_front());
        m_nack = 0;
      end
    end
  endtask

  // Monitor: compares presented outputs against the model every cycle
  always begin
    @(negedge clk);
    #1;
    if (active) begin
      fetching = m_started && !m_err && (exp_pc.size() == 0);
      check("add_a", add_a, m_pc);
      check("add_b", add_b, 32'd4);
      check("imem_req", {31'd0, imem_req}, {31'd0, fetching});
      if (fetching) check("imem_addr", imem_addr, m_pc);
      check("instr_valid", {31'd0, instr_valid},
            {31'd0, exp_pc.size() != 0});
      if (exp_pc.size() != 0) begin
        check("instr", instr, exp_ins[0]);
        check("instr_pc", instr_pc, exp_pc[0]);
      end
      check("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
    end
  end

  initial begin
    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_checks();
    for (int r = 0; r < NRUN; r++) begin
      ack_pct = ack_t[r];
      rdy_pct = rdy_t[r];
      rd_pct  = rd_t[r];
      mis_pct = mis_t[r];
      @(negedge clk);
      rst_n  = 1'b1;
      active = 1'b1;
      repeat (cyc_t[r]) begin
        #2;
        drive();
        @(negedge clk);
      end
      #3;
      active = 1'b0;
      imem_ack = 1'b1;
      rst_n = 1'b0;
      model_reset();
      #1;
      reset_checks();
      @(negedge clk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter and instruction-fetch controller for the single-cycle RISC datapath. Holds the architectural PC and drives it with a constant 4 into the existing 32-bit ripple adder. Takes the sum back as the sequential next PC. Fetches instructions over a req/ack instruction-memory handshake and presents each to decode through a valid/ready handshake, with branch/jump redirect and fetch-error detection.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded by reset; must be word-aligned.
- TIMEOUT_CYCLES, 15, maximum FETCH cycles without imem_ack before error; range 1..255.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- add_a  out  32  adder operand A = current PC.
- add_b  out  32  adder operand B = constant 32'd4.
- add_s  in  32  adder sum (PC+4), combinational return.
- imem_req  out  1  fetch request for imem_addr.
- imem_addr  out  32  fetch address = PC.
- imem_ack  in  1  imem_rdata valid for imem_addr this cycle.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  instr/instr_pc hold a fetched instruction.
- instr  out  32  fetched instruction.
- instr_pc  out  32  address of instr.
- instr_ready  in  1  decode accepts instr this cycle.
- redirect  in  1  branch/jump taken; load redirect_pc.
- redirect_pc  in  32  redirect target.
- fetch_err  out  1  sticky error flag.

## Operation
- States: IDLE, FETCH, HOLD, ERR.
- IDLE: entered only by reset; unconditionally moves to FETCH next cycle.
- FETCH:
  - imem_req=1; imem_addr=pc.
  - Memory samples the address every requesting cycle; a changed address abandons the prior request.
  - On imem_ack: instr<=imem_rdata, instr_pc<=pc, pc<=add_s, go to HOLD.
- HOLD:
  - instr_valid=1; instr and instr_pc stable.
  - On instr_ready: go to FETCH.
  - One-deep buffer; no fetch overlaps HOLD.
- Redirect, accepted in FETCH or HOLD, priority over imem_ack and instr_ready:
  - pc<=redirect_pc, state to FETCH.
  - Held or arriving instruction is discarded; instr_valid is 0 next cycle.
- Misaligned redirect (redirect_pc[1:0]!=0): go to ERR instead; pc unchanged.
- ERR: imem_req=0, instr_valid=0, fetch_err=1; exits only via rst_n.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC → 0), no error. The adder carry-out is not used.
- Redirect in IDLE or ERR is ignored.

## Timing
- Reset values: pc=RESET_VECTOR, state=IDLE, imem_req=0, instr_valid=0, instr=0, instr_pc=0, fetch_err=0. add_a=RESET_VECTOR and add_b=4 throughout.
- rst_n assertion mid-fetch clears state immediately (async); any outstanding ack is ignored.
- First imem_req: the first clk edge after rst_n deasserts enters FETCH, so imem_req is high in the second cycle.
- Latency: ack in cycle N gives instr_valid=1 in cycle N+1. Ready in cycle M gives imem_req=1 in cycle M+1. Best-case throughput is 1 instruction per 2 cycles.
- imem_req, instr_valid and fetch_err are decoded from the registered state (Moore); no combinational path from inputs to outputs.
- add_s must settle within one cycle; it is sampled only on the ack edge.

## Configuration
- FETCH_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to FETCH and on redirect.
  - It increments each FETCH cycle without ack.
  - Reaching TIMEOUT_CYCLES moves the block to ERR on that edge.
- FETCH_TIMEOUT_EN undefined: the counter is absent, FETCH waits indefinitely, and fetch_err is set only by a misaligned redirect.

## Structure
- Shared package pc_fetch_pkg holds:
  - state enum (IDLE, FETCH, HOLD, ERR);
  - INSTR_BYTES = 32'd4 (drives add_b);
  - default RESET_VECTOR.
- Sub-module fetch_timeout_ctr (counter plus compare, exists only under FETCH_TIMEOUT_EN).
- The adder stays external.

## Test plan
- Reset release, imem_ack in the first FETCH cycle, rdata 32'h0000_0013 → imem_addr=0. Next cycle: instr_valid=1, instr=32'h13, instr_pc=0, add_a=4.
- instr_ready held 0 for 5 cycles during HOLD → instr stable and imem_req=0 throughout; ready=1 → next fetch at address 4.
- Redirect to 32'h0000_0100 in the same cycle as imem_ack → data discarded, instr_valid stays 0, next imem_addr=32'h100.
- Redirect to 32'h0000_0102 → fetch_err=1 next cycle, imem_req=0 until rst_n.
- PC at 32'hFFFF_FFFC acked → next imem_addr=0, no error.
- With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=15, no ack for 15 FETCH cycles → fetch_err=1 on the 15th edge. Without the macro, 100 cycles without ack → fetch_err stays 0.
